// File: rtl/sdram_tg_pkg.sv
// Shared state encoding and pattern constants for the SDRAM traffic generator.
package sdram_tg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_INIT,
    WRITE,
    WAIT_RD,
    READ,
    DONE
  } tg_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 as bit positions 0,2,3,5 of a right-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/sdram_tg_if.sv
// FIFO-side bus of the traffic generator: write-FIFO push port and read-FIFO pop/data port.
interface sdram_tg_if #(
  parameter int DATA_W = 16
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  modport master (output wr_en, output wr_data, output rd_en, input  rd_data);
  modport slave  (input  wr_en, input  wr_data, input  rd_en, output rd_data);
endinterface

// File: rtl/sdram_tg_pattern.sv
// Test-pattern word generator: load returns to the seed, advance steps to the next word.
// SDRAM_TG_LFSR_EN selects a 16-bit Fibonacci LFSR; otherwise an incrementing count from 1.
module sdram_tg_pattern
  import sdram_tg_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_adv,
  output logic [DATA_W-1:0] o_word
);

`ifdef SDRAM_TG_LFSR_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_adv) begin
      r_lfsr <= {^(r_lfsr & LFSR_TAPS), r_lfsr[15:1]};
    end
  end

  assign o_word = DATA_W'(r_lfsr);
`else
  logic [DATA_W-1:0] r_word;

  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_word <= DATA_W'(1);
    end else if (i_adv) begin
      r_word <= r_word + DATA_W'(1);
    end
  end

  assign o_word = r_word;
`endif

endmodule

// File: rtl/sdram_traffic_gen.sv
// SDRAM self-test: write a BURST_LEN pattern into the write FIFO, wait RD_DELAY, read it back and compare.
// Pattern source is selected by SDRAM_TG_LFSR_EN (see sdram_tg_pattern).
module sdram_traffic_gen
  import sdram_tg_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 128,
  parameter int RD_DELAY  = 1000
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        sdram_init_done,
  input  logic        loop_en,
  sdram_tg_if.master  fifo,
  output logic        error_flag,
  output logic [15:0] err_cnt,
  output logic [15:0] pass_cnt,
  output logic        busy
);

  localparam int CNT_MAX = (BURST_LEN > RD_DELAY) ? BURST_LEN : RD_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic              r_init_meta;
  logic              r_init_sync;
  tg_state_t         r_state;
  tg_state_t         w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              r_cmp_vld;
  logic              w_cmp;
  logic              w_mismatch;
  logic              w_pass_done;
  logic              r_err_flag;
  logic [15:0]       r_err_cnt;
  logic [15:0]       r_pass_cnt;
  logic [DATA_W-1:0] w_wr_word;
  logic [DATA_W-1:0] w_exp_word;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_init_meta <= 1'b0;
      r_init_sync <= 1'b0;
    end else begin
      r_init_meta <= sdram_init_done;
      r_init_sync <= r_init_meta;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = WAIT_INIT;
      WAIT_INIT: begin
        w_cnt_nxt = '0;
        if (r_init_sync) w_state_nxt = WRITE;
      end
      WRITE: begin
        w_wr_en   = 1'b1;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(BURST_LEN - 1)) begin
          w_state_nxt = WAIT_RD;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_RD: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(RD_DELAY - 1)) begin
          w_state_nxt = READ;
          w_cnt_nxt   = '0;
        end
      end
      READ: begin
        // One extra cycle past the last rd_en so the final word is compared before DONE
        w_rd_en   = (r_cnt != CNT_W'(BURST_LEN));
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(BURST_LEN)) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
        end
      end
      DONE: begin
        w_cnt_nxt = '0;
        if (loop_en) w_state_nxt = WRITE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Losing init mid-pass abandons the pass; enables drop in the same cycle
    if (!r_init_sync && (r_state == WRITE || r_state == WAIT_RD || r_state == READ)) begin
      w_state_nxt = WAIT_INIT;
      w_cnt_nxt   = '0;
      w_wr_en     = 1'b0;
      w_rd_en     = 1'b0;
    end
  end

  assign w_cmp       = r_cmp_vld && (r_state == READ) && r_init_sync;
  assign w_mismatch  = w_cmp && (fifo.rd_data != w_exp_word);
  assign w_pass_done = (r_state == READ) && (w_state_nxt == DONE);

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_cmp_vld  <= 1'b0;
      r_err_flag <= 1'b0;
      r_err_cnt  <= '0;
      r_pass_cnt <= '0;
    end else begin
      r_cmp_vld <= w_rd_en;
      if (w_mismatch) begin
        r_err_flag <= 1'b1;
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
      end
      if (w_pass_done) r_pass_cnt <= r_pass_cnt + 16'd1;
    end
  end

  sdram_tg_pattern #(.DATA_W(DATA_W)) u_wr_pat (
    .clk    (clk_50m),
    .rst    (rst),
    .i_load (r_state != WRITE),
    .i_adv  (w_wr_en),
    .o_word (w_wr_word)
  );

  sdram_tg_pattern #(.DATA_W(DATA_W)) u_exp_pat (
    .clk    (clk_50m),
    .rst    (rst),
    .i_load (r_state != READ),
    .i_adv  (w_cmp),
    .o_word (w_exp_word)
  );

  assign fifo.wr_en   = w_wr_en;
  assign fifo.wr_data = w_wr_en ? w_wr_word : '0;
  assign fifo.rd_en   = w_rd_en;
  assign error_flag   = r_err_flag;
  assign err_cnt      = r_err_cnt;
  assign pass_cnt     = r_pass_cnt;
  assign busy         = (r_state != IDLE) && (r_state != DONE);

endmodule
